// File: rtl/instr_mem_responder_if.sv
// Fetch/load bus between an LC3-style fetch master and the instruction memory responder.
// The master drives the fetch request and program-load strobe; the responder returns
// the fetched word, its completion pulse and status.
interface instr_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] PC;
    logic              instrmem_rd;
    logic [DATA_W-1:0] instr_dout;
    logic              complete_instr;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              busy;
    logic              addr_err;
    logic [31:0]       fetch_count;

    modport master (
        output PC, instrmem_rd, load_en, load_addr, load_data,
        input  instr_dout, complete_instr, busy, addr_err, fetch_count
    );

    modport slave (
        input  PC, instrmem_rd, load_en, load_addr, load_data,
        output instr_dout, complete_instr, busy, addr_err, fetch_count
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder with fixed read latency, program-load port,
// out-of-range detection and a saturating fetch counter. One fetch in flight at a time.
module instr_mem_responder #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter int              DEPTH    = 256,
    parameter int              LATENCY  = 2,
    parameter logic [DATA_W-1:0] OOR_WORD = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_mem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_next;
    logic [3:0]        lat_cnt, lat_cnt_next;
    logic              accept;
    logic              enter_resp;
    logic              pc_oor;
    logic              load_ok;
    logic [IDX_W-1:0]  pc_idx;
    logic [IDX_W-1:0]  load_idx;
    logic              oor_flag;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] last_dout;
    logic [DATA_W-1:0] resp_word;
    logic [31:0]       count;

    logic [DATA_W-1:0] mem [DEPTH];

    // Full-width address compares: bits above the index only matter here.
    assign pc_oor   = (64'(bus.PC) >= 64'(DEPTH));
    assign load_ok  = (64'(bus.load_addr) < 64'(DEPTH));
    assign pc_idx   = bus.PC[IDX_W-1:0];
    assign load_idx = bus.load_addr[IDX_W-1:0];

    // Next-state logic: accept in IDLE only, count down in WAIT, single RESP cycle.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.instrmem_rd) begin
                    accept       = 1'b1;
                    lat_cnt_next = LAT_M1;
                    state_next   = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (lat_cnt <= 4'd1) begin
                    lat_cnt_next = 4'd0;
                    state_next   = RESP;
                end else begin
                    lat_cnt_next = lat_cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

    // Memory: loads land every cycle; the fetch word is captured at the request edge,
    // so a same-edge load to the same address is seen by the next fetch only.
    always_ff @(posedge clock) begin
        if (bus.load_en && load_ok) begin
            mem[load_idx] <= bus.load_data;
        end
        if (accept) begin
            rd_data <= mem[pc_idx];
        end
    end

    // Control and status registers; reset aborts any fetch in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_cnt   <= 4'd0;
            oor_flag  <= 1'b0;
            last_dout <= '0;
            count     <= 32'd0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
            if (accept) begin
                oor_flag <= pc_oor;
            end
            if (enter_resp && (count != 32'hFFFF_FFFF)) begin
                count <= count + 32'd1;
            end
            if (state == RESP) begin
                last_dout <= resp_word;
            end
        end
    end

    assign resp_word          = oor_flag ? OOR_WORD : rd_data;
    assign bus.instr_dout     = (state == RESP) ? resp_word : last_dout;
    assign bus.complete_instr = (state == RESP);
    assign bus.addr_err       = (state == RESP) && oor_flag;
    assign bus.busy           = (state != IDLE);
    assign bus.fetch_count    = count;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two builds (LATENCY=2 and LATENCY=1) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_instr_mem_responder;
    localparam int          DEPTH = 256;
    localparam logic [15:0] OOR   = 16'hDEAD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0, laddr = '0, ldata = '0;
    logic        rd = 1'b0, len = 1'b0;

    always #5 clock = ~clock;

    instr_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    instr_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    assign bus0.PC = pc;  assign bus0.instrmem_rd = rd;
    assign bus0.load_en = len;  assign bus0.load_addr = laddr;  assign bus0.load_data = ldata;
    assign bus1.PC = pc;  assign bus1.instrmem_rd = rd;
    assign bus1.load_en = len;  assign bus1.load_addr = laddr;  assign bus1.load_data = ldata;

    instr_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(2), .OOR_WORD(OOR))
        u0 (.clock(clock), .reset(reset), .bus(bus0));
    instr_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(1), .OOR_WORD(OOR))
        u1 (.clock(clock), .reset(reset), .bus(bus1));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          lat [2] = '{2, 1};
    logic [15:0] mem_m [DEPTH];
    longint      edge_no = 0;
    longint      next_acc [2];
    longint      req_edge [2];
    bit          have [2];
    logic [15:0] hold_d [2];
    bit          hold_oor [2];
    logic [15:0] last_d [2];
    logic [31:0] cnt_m [2];

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            next_acc[d] = 0; req_edge[d] = 0; have[d] = 0;
            hold_d[d] = '0; hold_oor[d] = 0; last_d[d] = '0; cnt_m[d] = 0;
        end
    endtask

    task automatic model_step();
        edge_no++;
        for (int d = 0; d < 2; d++) begin
            if (rd && edge_no >= next_acc[d]) begin
                have[d]     = 1;
                req_edge[d] = edge_no;
                next_acc[d] = edge_no + lat[d] + 1;
                hold_oor[d] = (pc >= DEPTH);
                hold_d[d]   = hold_oor[d] ? OOR : mem_m[pc[7:0]];
            end
            if (have[d] && edge_no == req_edge[d] + lat[d] - 1) begin
                last_d[d] = hold_d[d];
                if (cnt_m[d] != 32'hFFFF_FFFF) cnt_m[d] = cnt_m[d] + 1;
            end
        end
        if (len && laddr < DEPTH) mem_m[laddr[7:0]] = ldata;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int          pulses [2] = '{0, 0};
    logic [15:0] p_data [2];
    logic        p_err [2];

    task automatic check_dut(input int d, input logic c, input logic b, input logic e,
                             input logic [15:0] dout, input logic [31:0] fc);
        bit exp_c, exp_b;
        exp_c = have[d] && (edge_no == req_edge[d] + lat[d] - 1);
        exp_b = have[d] && (edge_no >= req_edge[d]) && (edge_no <= req_edge[d] + lat[d] - 1);
        chk($sformatf("u%0d.complete_instr", d), 32'(c), 32'(exp_c));
        chk($sformatf("u%0d.busy", d), 32'(b), 32'(exp_b));
        chk($sformatf("u%0d.addr_err", d), 32'(e), 32'(exp_c && hold_oor[d]));
        chk($sformatf("u%0d.instr_dout", d), 32'(dout), 32'(last_d[d]));
        chk($sformatf("u%0d.fetch_count", d), fc, cnt_m[d]);
        if (c === 1'b1) begin
            pulses[d]++;
            p_data[d] = dout;
            p_err[d]  = e;
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            check_dut(0, bus0.complete_instr, bus0.busy, bus0.addr_err, bus0.instr_dout, bus0.fetch_count);
            check_dut(1, bus1.complete_instr, bus1.busy, bus1.addr_err, bus1.instr_dout, bus1.fetch_count);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int k = 0;
        #1;
        while ((bus0.busy || bus1.busy) && k < 20) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (k >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: busy still high after %0d cycles, required idle", k);
        end
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        len = 1'b1; laddr = a; ldata = d;
        @(negedge clock);
        len = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a, input int hold);
        @(negedge clock);
        pc = a; rd = 1'b1;
        repeat (hold) @(negedge clock);
        rd = 1'b0;
        wait_idle();
    endtask

    logic [15:0] prog [4] = '{16'h1021, 16'h5020, 16'h0E02, 16'hF025};
    int pa0, pa1;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("reset.busy", 32'(bus0.busy), 32'd0);
        chk("reset.complete", 32'(bus0.complete_instr), 32'd0);
        chk("reset.fetch_count", bus0.fetch_count, 32'd0);
        chk("reset.instr_dout", 32'(bus0.instr_dout), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) do_load(16'(i), prog[i]);
        do_load(16'd5, 16'h1234);
        do_load(16'd7, 16'h5555);

        for (int i = 0; i < 4; i++) begin
            fetch(16'(i), 1);
            chk($sformatf("prog%0d.u0", i), 32'(p_data[0]), 32'(prog[i]));
            chk($sformatf("prog%0d.u1", i), 32'(p_data[1]), 32'(prog[i]));
            $display("fetch PC=%0d -> u0 %h u1 %h", i, p_data[0], p_data[1]);
        end
        chk("count4.u0", bus0.fetch_count, 32'd4);
        chk("count4.u1", bus1.fetch_count, 32'd4);

        // Request held across the busy window: extra edges are ignored.
        pa0 = pulses[0]; pa1 = pulses[1];
        fetch(16'd5, 3);
        chk("hold.u0.pulses", 32'(pulses[0] - pa0), 32'd1);
        chk("hold.u1.pulses", 32'(pulses[1] - pa1), 32'd2);
        chk("hold.u0.data", 32'(p_data[0]), 32'h1234);
        $display("held fetch PC=5 -> u0 pulses %0d data %h", pulses[0] - pa0, p_data[0]);

        fetch(16'h0100, 1);
        chk("oor.u0.data", 32'(p_data[0]), 32'(OOR));
        chk("oor.u0.err", 32'(p_err[0]), 32'd1);
        chk("oor.u1.err", 32'(p_err[1]), 32'd1);
        $display("fetch PC=0100 -> u0 %h addr_err %0d", p_data[0], p_err[0]);

        // Same-edge load and fetch to one address: old word returned, write lands.
        @(negedge clock);
        pc = 16'd7; rd = 1'b1; len = 1'b1; laddr = 16'd7; ldata = 16'hAAAA;
        @(negedge clock);
        rd = 1'b0; len = 1'b0;
        wait_idle();
        chk("rbw.old.u0", 32'(p_data[0]), 32'h5555);
        chk("rbw.old.u1", 32'(p_data[1]), 32'h5555);
        fetch(16'd7, 1);
        chk("rbw.new.u0", 32'(p_data[0]), 32'hAAAA);
        $display("same-edge load/fetch PC=7 -> then %h", p_data[0]);

        // Out-of-range load is dropped rather than aliasing onto index 1.
        do_load(16'h0101, 16'hBEEF);
        fetch(16'd1, 1);
        chk("oorload.u0", 32'(p_data[0]), 32'h5020);

        // Reset mid-fetch: outputs clear asynchronously, no completion.
        @(negedge clock);
        pc = 16'd2; rd = 1'b1;
        @(posedge clock);
        #2;
        rd = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst.u0.busy", 32'(bus0.busy), 32'd0);
        chk("arst.u0.complete", 32'(bus0.complete_instr), 32'd0);
        chk("arst.u0.count", bus0.fetch_count, 32'd0);
        chk("arst.u1.complete", 32'(bus1.complete_instr), 32'd0);
        pa0 = pulses[0];
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("arst.u0.nopulse", 32'(pulses[0] - pa0), 32'd0);
        fetch(16'd3, 1);
        chk("arst.after.data", 32'(p_data[0]), 32'hF025);
        chk("arst.after.count", bus0.fetch_count, 32'd1);
        $display("reset during WAIT, then fetch PC=3 -> %h count %0d", p_data[0], bus0.fetch_count);

        // Continuous requests: accepted every LATENCY+1 edges.
        pa0 = pulses[0]; pa1 = pulses[1];
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            pc = 16'(i % 4); rd = 1'b1;
        end
        @(negedge clock);
        rd = 1'b0;
        wait_idle();
        chk("b2b.u0.pulses", 32'(pulses[0] - pa0), 32'd3);
        chk("b2b.u1.pulses", 32'(pulses[1] - pa1), 32'd4);
        $display("back-to-back 8 edges -> u0 %0d pulses, u1 %0d pulses", pulses[0] - pa0, pulses[1] - pa1);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
